// File: rtl/vehicle_trip_sequencer.sv
// rtl/vehicle_trip_sequencer.sv - trip phase sequencer with filtered thermal shutdown
module vehicle_trip_sequencer #(
    parameter int OVH_FILTER     = 2,
    parameter int COOL_CYCLES    = 8,
    parameter int REFUEL_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_trip,
    input  logic       cpu_overheated,
    input  logic       arrived,
    input  logic       gas_tank_empty,
    input  logic       refuel_done,
    output logic       shut_off_computer,
    output logic       keep_driving,
    output logic [2:0] state_o,
    output logic       trip_done,
    output logic       refuel_fault
);

    localparam int OW = $clog2(OVH_FILTER + 1);
    localparam int CW = $clog2(COOL_CYCLES + 1);
    localparam int TW = $clog2(REFUEL_TIMEOUT + 1);

    localparam logic [OW-1:0] OVH_LAST  = OW'(OVH_FILTER - 1);
    localparam logic [CW-1:0] COOL_LAST = CW'(COOL_CYCLES - 1);
    localparam logic [TW-1:0] TMR_LAST  = TW'(REFUEL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        REFUEL = 3'd2,
        DONE   = 3'd3,
        FAULT  = 3'd4
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [OW-1:0]   ovh_cnt;
    logic [CW-1:0]   cool_cnt;
    logic [TW-1:0]   refuel_tmr;
    logic            state_legal;

    assign state_legal  = (state == IDLE) || (state == DRIVE) || (state == REFUEL) ||
                          (state == DONE) || (state == FAULT);
    assign state_o      = state;
    assign keep_driving = (state == DRIVE) & ~arrived & ~gas_tank_empty & ~shut_off_computer;

    // Next trip phase from the current phase and the sensor inputs
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (start_trip) next_state = DRIVE;
            DRIVE: begin
                if (arrived)             next_state = DONE;
                else if (gas_tank_empty) next_state = REFUEL;
            end
            REFUEL: begin
                if (refuel_done && !gas_tank_empty) next_state = DRIVE;
                else if (refuel_tmr == TMR_LAST)    next_state = FAULT;
            end
            DONE:   if (start_trip) next_state = DRIVE;
            FAULT:  next_state = FAULT;
            default: next_state = IDLE;
        endcase
    end

    // Thermal filter: debounce overheat into shutdown, then hold off until cooled
    always_ff @(posedge clk) begin
        if (reset) begin
            shut_off_computer <= 1'b0;
            ovh_cnt           <= '0;
            cool_cnt          <= '0;
        end else if (!shut_off_computer) begin
            cool_cnt <= '0;
            if (cpu_overheated) begin
                if (ovh_cnt == OVH_LAST) begin
                    shut_off_computer <= 1'b1;
                    ovh_cnt           <= '0;
                end else begin
                    ovh_cnt <= ovh_cnt + 1'b1;
                end
            end else begin
                ovh_cnt <= '0;
            end
        end else begin
            ovh_cnt <= '0;
            if (!cpu_overheated) begin
                if (cool_cnt == COOL_LAST) begin
                    shut_off_computer <= 1'b0;
                    cool_cnt          <= '0;
                end else begin
                    cool_cnt <= cool_cnt + 1'b1;
                end
            end else begin
                cool_cnt <= '0;
            end
        end
    end

    // Trip FSM with registered phase flags; frozen by the pre-edge shutdown level
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            refuel_tmr   <= '0;
            trip_done    <= 1'b0;
            refuel_fault <= 1'b0;
        end else if (!shut_off_computer || !state_legal) begin
            state        <= next_state;
            trip_done    <= (next_state == DONE);
            refuel_fault <= (next_state == FAULT);
            if (state == DRIVE && next_state == REFUEL) begin
                refuel_tmr <= '0;
            end else if (state == REFUEL && refuel_tmr != TMR_LAST) begin
                refuel_tmr <= refuel_tmr + 1'b1;
            end
        end
    end

endmodule
